// File: rtl/instruction_encoder_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : instruction_encoder_stream                              |
// | Function : Packs op/dst/src fields into 8-bit words, buffers them  |
// |            in a FIFO and streams them out with sequential address. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module instruction_encoder_stream #(
    parameter int          DEPTH        = 4,
    parameter int          ADDR_W       = 8,
    parameter logic [15:0] ILLEGAL_MASK = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op_code,
    input  logic [1:0]               in_destination_register,
    input  logic [1:0]               in_source_register,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_instruction,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     illegal_pulse,
    output logic [7:0]               illegal_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic [7:0]         r_out_instr;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_pulse;
    logic [7:0]         r_count;

    logic [7:0]         w_word;
    logic               w_illegal;
    logic               w_push;
    logic               w_write;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_rd_next;
    logic [c_LVL_W-1:0] w_level_next;
    logic [7:0]         w_head_next;

    assign w_word    = {in_op_code, in_destination_register, in_source_register};
    assign w_illegal = ILLEGAL_MASK[in_op_code];

    assign in_ready  = (r_level < c_LVL_W'(DEPTH)) && !rst;
    assign out_valid = (r_level != '0);

    assign w_push  = in_valid && in_ready;
    assign w_write = w_push && !w_illegal;
    assign w_pop   = out_valid && out_ready;

    assign w_rd_next = w_pop ? c_PTR_W'(r_rd_ptr + 1'b1) : r_rd_ptr;

    always_comb begin
        w_level_next = r_level;
        case ({w_write, w_pop})
            2'b10:   w_level_next = c_LVL_W'(r_level + 1'b1);
            2'b01:   w_level_next = c_LVL_W'(r_level - 1'b1);
            default: w_level_next = r_level;
        endcase
    end

    // The write slot equals the new head only when the FIFO would otherwise
    // be empty after this edge, so the incoming word becomes the head directly.
    assign w_head_next = (w_write && (r_wr_ptr == w_rd_next)) ? w_word : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_out_instr <= '0;
            r_addr      <= '0;
            r_pulse     <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= c_PTR_W'(r_wr_ptr + 1'b1);
            end
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            // Output word holds its last value while the FIFO is empty.
            if (w_level_next != '0) begin
                r_out_instr <= w_head_next;
            end
            if (w_pop) begin
                r_addr <= ADDR_W'(r_addr + 1'b1);
            end
            r_pulse <= w_push && w_illegal;
            if (w_push && w_illegal && (r_count != 8'hFF)) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign out_instruction = r_out_instr;
    assign out_addr        = r_addr;
    assign illegal_pulse   = r_pulse;
    assign illegal_count   = r_count;
    assign fifo_level      = r_level;

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_instruction_encoder_stream                           |
// | Function : Self-checking bench with a queue-based reference model. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_instruction_encoder_stream;

    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 8;
    localparam logic [15:0] MASK   = 16'h8000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op_code;
    logic [1:0]  in_destination_register;
    logic [1:0]  in_source_register;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_instruction;
    logic [ADDR_W-1:0] out_addr;
    logic        illegal_pulse;
    logic [7:0]  illegal_count;
    logic [$clog2(DEPTH):0] fifo_level;

    instruction_encoder_stream #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ILLEGAL_MASK(MASK)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op_code(in_op_code),
        .in_destination_register(in_destination_register),
        .in_source_register(in_source_register),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_addr(out_addr),
        .illegal_pulse(illegal_pulse), .illegal_count(illegal_count),
        .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of pending words plus simple counters.
    logic [7:0] m_q[$];
    int         m_addr;
    int         m_cnt;
    bit         m_pulse;
    logic [7:0] m_last;
    bit         m_push;

    typedef struct {
        logic [3:0] op;
        logic [1:0] dst;
        logic [1:0] src;
        logic [7:0] exp_word;
        bit         exp_illegal;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit push, pop, ill;
        if (rst) begin
            m_q.delete();
            m_addr = 0; m_cnt = 0; m_pulse = 0; m_last = 8'h00; m_push = 0;
        end else begin
            push = in_valid && (m_q.size() < DEPTH);
            pop  = (m_q.size() != 0) && out_ready;
            ill  = MASK[in_op_code];
            m_push  = push;
            m_pulse = push && ill;
            if (pop) begin
                void'(m_q.pop_front());
                m_addr = (m_addr + 1) % (1 << ADDR_W);
            end
            if (push) begin
                if (ill) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                else m_q.push_back({in_op_code, in_destination_register, in_source_register});
            end
            if (m_q.size() != 0) m_last = m_q[0];
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("out_instruction", 32'(out_instruction), 32'(m_last));
        check("out_addr", 32'(out_addr), 32'(m_addr));
        check("illegal_pulse", 32'(illegal_pulse), 32'(m_pulse));
        check("illegal_count", 32'(illegal_count), 32'(m_cnt));
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("in_ready", 32'(in_ready), 32'((m_q.size() < DEPTH) && !rst));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_word(input logic [7:0] w);
        in_op_code = w[7:4];
        in_destination_register = w[3:2];
        in_source_register = w[1:0];
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    logic [7:0] w_exp[5];
    logic [7:0] rnd;
    int pulses;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op_code = '0; in_destination_register = '0; in_source_register = '0;
        m_q.delete(); m_addr = 0; m_cnt = 0; m_pulse = 0; m_last = 8'h00; m_push = 0;
        @(negedge clk);
        do_reset();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_instr", 32'(out_instruction), 32'd0);

        // Test 1: single word A9
        in_valid = 1'b1; out_ready = 1'b1; set_word(8'hA9);
        step();
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_instr", 32'(out_instruction), 32'hA9);
        check("t1_addr", 32'(out_addr), 32'd0);
        step();
        check("t1_addr_after", 32'(out_addr), 32'd1);
        check("t1_level_after", 32'(fifo_level), 32'd0);

        // Table-driven encoding vectors
        vecs[0] = '{4'hA, 2'd2, 2'd1, 8'hA9, 1'b0};
        vecs[1] = '{4'h0, 2'd0, 2'd0, 8'h00, 1'b0};
        vecs[2] = '{4'hF, 2'd3, 2'd3, 8'h00, 1'b1};
        vecs[3] = '{4'h7, 2'd1, 2'd2, 8'h76, 1'b0};
        vecs[4] = '{4'hC, 2'd3, 2'd0, 8'hCC, 1'b0};
        vecs[5] = '{4'h5, 2'd2, 2'd3, 8'h5B, 1'b0};
        vecs[6] = '{4'hE, 2'd0, 2'd1, 8'hE1, 1'b0};
        vecs[7] = '{4'h3, 2'd3, 2'd3, 8'h3F, 1'b0};
        foreach (vecs[i]) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_op_code = vecs[i].op;
            in_destination_register = vecs[i].dst;
            in_source_register = vecs[i].src;
            step();
            in_valid = 1'b0;
            check("vec_pulse", 32'(illegal_pulse), 32'(vecs[i].exp_illegal));
            check("vec_valid", 32'(out_valid), 32'(!vecs[i].exp_illegal));
            if (!vecs[i].exp_illegal) check("vec_word", 32'(out_instruction), 32'(vecs[i].exp_word));
            step();
        end

        // Test 2: fill to full with out_ready low, then drain in order
        do_reset();
        w_exp[0] = 8'h10; w_exp[1] = 8'h21; w_exp[2] = 8'h32; w_exp[3] = 8'h43; w_exp[4] = 8'h54;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; set_word(w_exp[i]);
            step();
        end
        check("t2_full_level", 32'(fifo_level), 32'd4);
        check("t2_in_ready_low", 32'(in_ready), 32'd0);
        set_word(w_exp[4]); in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_order", 32'(out_instruction), 32'(w_exp[k]));
            check("t2_addr", 32'(out_addr), 32'(k));
            step();
            if (m_push) in_valid = 1'b0;
        end
        check("t2_drained", 32'(fifo_level), 32'd0);
        out_ready = 1'b0;

        // Test 3: illegal opcode then legal 8'h13
        do_reset();
        in_valid = 1'b1; set_word(8'hF0);
        step();
        in_valid = 1'b0;
        check("t3_pulse", 32'(illegal_pulse), 32'd1);
        check("t3_count", 32'(illegal_count), 32'd1);
        check("t3_nothing_out", 32'(out_valid), 32'd0);
        step();
        check("t3_pulse_one_cycle", 32'(illegal_pulse), 32'd0);
        in_valid = 1'b1; set_word(8'h13);
        step();
        in_valid = 1'b0;
        check("t3_instr", 32'(out_instruction), 32'h13);

        // Test 4: continuous stream of 300 words with address wrap
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rnd = 8'($urandom);
            if (rnd[7:4] == 4'hF) rnd[7:4] = 4'h9;
            set_word(rnd);
            step();
            check("t4_word", 32'(out_instruction), 32'(rnd));
            check("t4_addr", 32'(out_addr), 32'(i % 256));
            check("t4_level_le1", 32'(fifo_level <= 1), 32'd1);
            if (i == 256) check("t4_wrap", 32'(out_addr), 32'd0);
        end
        in_valid = 1'b0;
        step();

        // Test 5: 260 illegal pushes saturate the counter
        do_reset();
        pulses = 0;
        in_valid = 1'b1; set_word(8'hF5);
        for (int i = 0; i < 260; i++) begin
            step();
            if (illegal_pulse) pulses++;
        end
        in_valid = 1'b0;
        check("t5_count_sat", 32'(illegal_count), 32'd255);
        check("t5_pulses", 32'(pulses), 32'd260);
        check("t5_empty", 32'(fifo_level), 32'd0);
        step();

        // Test 6: reset during push+pop with 3 words held
        do_reset();
        in_valid = 1'b1; set_word(8'hF1);
        step();
        for (int i = 0; i < 3; i++) begin
            set_word(8'(8'h20 + i));
            step();
        end
        check("t6_pre_level", 32'(fifo_level), 32'd3);
        set_word(8'h66); out_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_addr", 32'(out_addr), 32'd0);
        check("t6_count", 32'(illegal_count), 32'd0);
        in_valid = 1'b1; set_word(8'h7B); out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("t6_first_addr", 32'(out_addr), 32'd0);
        check("t6_first_word", 32'(out_instruction), 32'h7B);
        out_ready = 1'b1;
        step();

        // Random mixed traffic against the model
        for (int i = 0; i < 500; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            set_word(8'($urandom));
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_encoder_stream.md
Name: instruction_encoder_stream

Overview:
- Inverse of the team's 8-bit instruction decoder.
- Accepts opcode / destination-register / source-register fields over a valid/ready handshake and packs them into 8-bit instruction words.
- Buffers the packed words in a small FIFO and streams them out with a sequential instruction-memory address, ready for loading program memory.
- Rejects opcodes marked illegal and counts the rejections.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
ADDR_W, 8, width of out_addr; wraps modulo 2^ADDR_W
ILLEGAL_MASK, 16'h0000, bit i = 1 marks opcode i illegal

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input fields valid
in_ready  out  1  block can accept input this cycle
in_op_code  in  4  opcode field
in_destination_register  in  2  destination register field
in_source_register  in  2  source register field
out_valid  out  1  out_instruction/out_addr valid
out_ready  in  1  consumer accepts current word
out_instruction  out  8  encoded word
out_addr  out  ADDR_W  memory address of current output word
illegal_pulse  out  1  one-cycle flag: an illegal opcode was consumed
illegal_count  out  8  saturating count of rejected instructions
fifo_level  out  clog2(DEPTH)+1  entries currently held

Behaviour:
- Reset (rst=1 at a rising edge): all outputs are 0 from the next cycle: out_valid, out_instruction, out_addr, illegal_pulse, illegal_count, fifo_level. FIFO pointers cleared and buffered contents discarded. Reset takes priority over any simultaneous push or pop, including mid-stream.
- Encoding: word = {in_op_code, in_destination_register, in_source_register}, i.e. bits [7:4] = op, [3:2] = dst, [1:0] = src. Pure bit concatenation, no arithmetic.
- in_ready = (fifo_level < DEPTH) and not in reset. Combinational from registered level only; it does not depend on in_valid.
- Push: occurs when in_valid & in_ready at an edge.
  - Legal opcode (ILLEGAL_MASK[op] = 0): word written at the tail and fifo_level incremented.
  - Illegal opcode: the input is consumed (handshake completes) but nothing is written. illegal_pulse = 1 for exactly the following cycle. illegal_count increments, saturating at 255.
- Pop: occurs when out_valid & out_ready at an edge. Head advances, fifo_level decrements, and out_addr increments by 1, wrapping from 2^ADDR_W-1 to 0.
- out_valid = (fifo_level != 0). out_instruction shows the head entry.
  - When out_valid = 0, out_instruction holds its last value (0 after reset).
  - While out_valid = 1 and out_ready = 0, out_instruction and out_addr are held stable.
- Latency: a legal word pushed at edge N is visible with out_valid = 1 in the cycle after edge N. There is no same-cycle bypass from input to output.
- Simultaneous push + pop:
  - Level unchanged, both pointers advance.
  - When the FIFO is full, in_ready = 0, so only the pop happens; in_ready rises the next cycle.
  - Simultaneous illegal push + pop: pop proceeds, level decrements, pulse and count behave as above.
- Empty: a pop is impossible because out_valid = 0. out_addr does not change.
- Full: in_valid is ignored and the upstream must hold its fields. No overwrite ever occurs.
- Pointer wrap: read/write pointers are clog2(DEPTH) bits and wrap naturally. fifo_level distinguishes full from empty.
- illegal_count at 255 stays 255. illegal_pulse still fires on each rejection.
- No other state. Upstream fields are sampled only at the handshake edge.

Test Plan:
1. Reset, then push op=4'hA, dst=2, src=1, with out_ready = 1 → in the next cycle out_valid = 1, out_instruction = 8'hA9, out_addr = 0. After the pop, out_addr = 1 and fifo_level = 0.
2. Hold out_ready = 0 and push 5 legal words 8'h10, 8'h21, 8'h32, 8'h43, 8'h54 (DEPTH = 4) → in_ready falls after the 4th push, fifo_level = 4, and the 5th word waits. Raise out_ready → outputs 8'h10, 8'h21, 8'h32, 8'h43, 8'h54 in order with addresses 0-4 and no loss.
3. ILLEGAL_MASK = 16'h8000: push op = 4'hF → consumed, nothing output, illegal_pulse high for exactly 1 cycle, illegal_count = 1. Next push op = 4'h1, dst = 0, src = 3 → out_instruction = 8'h13.
4. Continuous stream with in_valid = out_ready = 1 on every cycle for 300 words → fifo_level stays ≤ 1 in steady state, each word appears one cycle after its push, and out_addr wraps 255 → 0 at word 256 (ADDR_W = 8).
5. 260 consecutive illegal pushes → illegal_count saturates at 255, pulse seen 260 times, FIFO stays empty.
6. Fill with 3 words, assert rst for 1 cycle during a push+pop edge → next cycle out_valid = 0, fifo_level = 0, out_addr = 0, illegal_count = 0. The first push after reset emerges at out_addr = 0.
